// File: rtl/w5300_bus_responder.sv
// w5300_bus_responder: slave-side model of the W5300 16-bit parallel host bus.
// It samples the async strobes/address/data, serves reads and commits writes
// against a register file, and emulates the chip reset/boot windows.
// Read data appears 3 cycles after cs_n/rd_n fall; writes commit 3 cycles
// after wr_n/cs_n rise. There is no backpressure: `ready` only reports whether
// the model is answering (Idle/RdAct/WrAct).
// Ports: clk/rst_n; w_rst_n, cs_n, rd_n, wr_n, addr, data (host bus);
//        loc_addr/loc_wr_en/loc_wr_data/loc_rd_data (local access);
//        wr_evt/wr_evt_addr/wr_evt_data (bus write events); ready; err_flags.
// Optional: define W5300_RESP_PROTOCOL_CHECK_EN to enable the sticky
// err_flags. When it is undefined, err_flags is tied to 0.
module w5300_bus_responder #(
  parameter int CLK_FREQ      = 100,
  parameter int REG_AW        = 6,
  parameter int RST_MIN_TICKS = 100,
  parameter int BOOT_TICKS    = 4000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              w_rst_n,
  input  logic              cs_n,
  input  logic              rd_n,
  input  logic              wr_n,
  input  logic [9:0]        addr,
  inout  wire  [15:0]       data,
  input  logic [REG_AW-1:0] loc_addr,
  input  logic              loc_wr_en,
  input  logic [15:0]       loc_wr_data,
  output logic [15:0]       loc_rd_data,
  output logic              wr_evt,
  output logic [9:0]        wr_evt_addr,
  output logic [15:0]       wr_evt_data,
  output logic              ready,
  output logic [2:0]        err_flags
);

  localparam int DEPTH = 1 << REG_AW;
  localparam int BC_W  = $clog2(BOOT_TICKS + 1);
  localparam logic [BC_W-1:0] BOOT_LAST = BC_W'(BOOT_TICKS - 1);
  localparam logic [15:0]     RST_MIN   = 16'(RST_MIN_TICKS);

  // Elaboration-time parameter sanity checks.
  if (CLK_FREQ <= 0) begin : g_bad_clk_freq
    $error("w5300_bus_responder: CLK_FREQ must be positive");
  end
  if (REG_AW < 1 || REG_AW > 9) begin : g_bad_reg_aw
    $error("w5300_bus_responder: REG_AW must be in 1..9");
  end

  typedef enum logic [2:0] {
    ST_RESET,
    ST_BOOT,
    ST_IDLE,
    ST_RD_ACT,
    ST_WR_ACT
  } state_t;

  state_t state, state_nxt;

  // Synchronizers: bit [1] is the synchronized value. Strobes idle high.
  logic [1:0]  w_rst_sync, cs_sync, rd_sync, wr_sync;
  // addr/data get the same two-stage delay so they line up with the strobes.
  logic [9:0]  addr_s1, addr_s2;
  logic [15:0] data_s1, data_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_rst_sync <= 2'b11;
      cs_sync    <= 2'b11;
      rd_sync    <= 2'b11;
      wr_sync    <= 2'b11;
      addr_s1    <= '0;
      addr_s2    <= '0;
      data_s1    <= '0;
      data_s2    <= '0;
    end else begin
      w_rst_sync <= {w_rst_sync[0], w_rst_n};
      cs_sync    <= {cs_sync[0], cs_n};
      rd_sync    <= {rd_sync[0], rd_n};
      wr_sync    <= {wr_sync[0], wr_n};
      addr_s1    <= addr;
      addr_s2    <= addr_s1;
      data_s1    <= data;
      data_s2    <= data_s1;
    end
  end

  logic w_rst_ok, rd_act, wr_act, in_range;
  logic [REG_AW-1:0] idx;

  assign w_rst_ok = w_rst_sync[1];
  assign rd_act   = !cs_sync[1] && !rd_sync[1] && wr_sync[1];
  assign wr_act   = !cs_sync[1] && !wr_sync[1] && rd_sync[1];
  assign in_range = (addr_s2[9:REG_AW] == '0);
  assign idx      = addr_s2[REG_AW-1:0];

  logic [15:0]       lowcnt;
  logic [BC_W-1:0]   boot_cnt;
  logic [15:0]       rd_val;
  logic [9:0]        wr_addr_q;
  logic [15:0]       wr_data_q;
  logic [15:0]       regfile [DEPTH];

  logic rd_entry, wr_latch, commit, clear_rf;

  // Next-state logic. A synchronized chip reset overrides every state and
  // aborts any transfer in flight (no commit).
  always_comb begin
    state_nxt = state;
    rd_entry  = 1'b0;
    wr_latch  = 1'b0;
    commit    = 1'b0;
    clear_rf  = 1'b0;
    if (!w_rst_ok) begin
      state_nxt = ST_RESET;
    end else begin
      case (state)
        ST_RESET: begin
          if (lowcnt >= RST_MIN) begin
            clear_rf  = 1'b1;
            state_nxt = ST_BOOT;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
        ST_BOOT: begin
          if (boot_cnt == BOOT_LAST) state_nxt = ST_IDLE;
        end
        ST_IDLE: begin
          if (rd_act) begin
            rd_entry  = 1'b1;
            state_nxt = ST_RD_ACT;
          end else if (wr_act) begin
            wr_latch  = 1'b1;
            state_nxt = ST_WR_ACT;
          end
        end
        ST_RD_ACT: begin
          if (!rd_act) state_nxt = ST_IDLE;
        end
        ST_WR_ACT: begin
          // Keep tracking addr/data while the strobe is held; the pair seen
          // on the last active cycle is the one committed.
          if (wr_act) begin
            wr_latch = 1'b1;
          end else begin
            commit    = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      lowcnt   <= '0;
      boot_cnt <= '0;
    end else begin
      state <= state_nxt;
      // The cycle that triggers entry into Reset counts as the first low cycle.
      if (!w_rst_ok) begin
        if (state != ST_RESET)    lowcnt <= 16'd1;
        else if (lowcnt != '1)    lowcnt <= lowcnt + 16'd1;
      end
      if (state == ST_BOOT) boot_cnt <= boot_cnt + BC_W'(1);
      else                  boot_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_val    <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      if (rd_entry) rd_val <= in_range ? regfile[idx] : 16'hFFFF;
      if (wr_latch) begin
        wr_addr_q <= addr_s2;
        wr_data_q <= data_s2;
      end
    end
  end

  logic              wr_in_range;
  logic [REG_AW-1:0] wr_idx;

  assign wr_in_range = (wr_addr_q[9:REG_AW] == '0);
  assign wr_idx      = wr_addr_q[REG_AW-1:0];

  // The bus commit is written after the local write so it wins a collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regfile[i] <= '0;
    end else if (clear_rf) begin
      for (int i = 0; i < DEPTH; i++) regfile[i] <= '0;
    end else begin
      if (loc_wr_en && state != ST_RESET) regfile[loc_addr] <= loc_wr_data;
      if (commit && wr_in_range)          regfile[wr_idx]   <= wr_data_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loc_rd_data <= '0;
      wr_evt      <= 1'b0;
      wr_evt_addr <= '0;
      wr_evt_data <= '0;
    end else begin
      loc_rd_data <= regfile[loc_addr];
      wr_evt      <= commit;
      if (commit) begin
        wr_evt_addr <= wr_addr_q;
        wr_evt_data <= wr_data_q;
      end
    end
  end

  // Pin drive is decoded from state so an rst_n assertion releases the bus
  // immediately. A read arriving during Boot is answered with zero while the
  // strobe is held; Boot itself never leaves its countdown.
  logic        drive_en;
  logic [15:0] drive_val;

  always_comb begin
    drive_en  = 1'b0;
    drive_val = rd_val;
    if (state == ST_RD_ACT && rd_act) begin
      drive_en = 1'b1;
    end else if (state == ST_BOOT && w_rst_ok && rd_act) begin
      drive_en  = 1'b1;
      drive_val = 16'h0000;
    end
  end

  assign data  = drive_en ? drive_val : 16'hzzzz;
  assign ready = w_rst_ok &&
                 (state == ST_IDLE || state == ST_RD_ACT || state == ST_WR_ACT);

`ifdef W5300_RESP_PROTOCOL_CHECK_EN
  logic [2:0] err_q;
  logic       glitch;

  assign glitch = (state == ST_RESET) && w_rst_ok && (lowcnt < RST_MIN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= '0;
    end else begin
      if (!cs_sync[1] && !rd_sync[1] && !wr_sync[1])           err_q[0] <= 1'b1;
      if (state == ST_BOOT && w_rst_ok && (rd_act || wr_act))  err_q[1] <= 1'b1;
      if (glitch)                                              err_q[2] <= 1'b1;
    end
  end

  assign err_flags = err_q;
`else
  assign err_flags = 3'b000;
`endif

endmodule

// File: tb/tb_w5300_bus_responder.sv
// Testbench for w5300_bus_responder: directed scenarios plus randomized
// local/bus traffic checked against a plain array model of the register file.
module tb_w5300_bus_responder;

  localparam int REG_AW   = 6;
  localparam int RST_MIN  = 100;
  localparam int BOOT     = 500;

`ifdef W5300_RESP_PROTOCOL_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              w_rst_n = 1'b1;
  logic              cs_n = 1'b1;
  logic              rd_n = 1'b1;
  logic              wr_n = 1'b1;
  logic [9:0]        addr = '0;
  logic [15:0]       tb_dat = '0;
  logic              tb_drv = 1'b0;
  wire  [15:0]       data;
  logic [REG_AW-1:0] loc_addr = '0;
  logic              loc_wr_en = 1'b0;
  logic [15:0]       loc_wr_data = '0;
  logic [15:0]       loc_rd_data;
  logic              wr_evt;
  logic [9:0]        wr_evt_addr;
  logic [15:0]       wr_evt_data;
  logic              ready;
  logic [2:0]        err_flags;

  assign data = tb_drv ? tb_dat : 16'hzzzz;

  always #5 clk = ~clk;

  w5300_bus_responder #(
    .CLK_FREQ(100), .REG_AW(REG_AW), .RST_MIN_TICKS(RST_MIN), .BOOT_TICKS(BOOT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .w_rst_n(w_rst_n),
    .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n), .addr(addr), .data(data),
    .loc_addr(loc_addr), .loc_wr_en(loc_wr_en), .loc_wr_data(loc_wr_data),
    .loc_rd_data(loc_rd_data),
    .wr_evt(wr_evt), .wr_evt_addr(wr_evt_addr), .wr_evt_data(wr_evt_data),
    .ready(ready), .err_flags(err_flags)
  );

  // Reference model: register contents and expected sticky error flags.
  logic [15:0] model_rf [64];
  logic [2:0]  exp_err;
  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 64; i++) model_rf[i] = 16'h0000;
  endtask

  task automatic do_rst();
    rst_n = 1'b0;
    step(3);
    rst_n = 1'b1;
    model_clear();
    exp_err = 3'b000;
    step(2);
  endtask

  // Drive a sentinel onto the bus; it reads back intact only if the DUT is Z.
  task automatic chk_bus_z(input string tag);
    tb_dat = 16'h5A3C;
    tb_drv = 1'b1;
    #1;
    chk(tag, data, 16'h5A3C);
    tb_drv = 1'b0;
  endtask

  task automatic loc_write(input logic [REG_AW-1:0] a, input logic [15:0] d);
    loc_addr    = a;
    loc_wr_data = d;
    loc_wr_en   = 1'b1;
    step(1);
    loc_wr_en   = 1'b0;
    model_rf[a] = d;
  endtask

  task automatic loc_check(input string tag, input logic [REG_AW-1:0] a);
    loc_addr = a;
    step(1);
    chk(tag, loc_rd_data, model_rf[a]);
  endtask

  task automatic bus_read(input string tag, input logic [9:0] a, input int hold);
    logic [15:0] exp;
    int evts;
    evts = 0;
    exp  = (a[9:REG_AW] == 0) ? model_rf[a[REG_AW-1:0]] : 16'hFFFF;
    addr = a;
    cs_n = 1'b0;
    rd_n = 1'b0;
    for (int k = 1; k <= hold; k++) begin
      step(1);
      if (wr_evt) evts++;
      if (k >= 3) chk(tag, data, exp);
    end
    cs_n = 1'b1;
    rd_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step(1);
      if (wr_evt) evts++;
    end
    chk({tag, "_no_wr_evt"}, evts, 0);
    chk_bus_z({tag, "_bus_z"});
  endtask

  task automatic bus_write(input logic [9:0] a, input logic [15:0] d, input int hold,
                           input bit coll);
    int pulses;
    pulses = 0;
    addr   = a;
    tb_dat = d;
    tb_drv = 1'b1;
    cs_n   = 1'b0;
    wr_n   = 1'b0;
    step(hold);
    // Strobes rise together with garbage on addr/data: the committed pair
    // must still be the one held while the strobe was active.
    cs_n   = 1'b1;
    wr_n   = 1'b1;
    addr   = 10'($urandom);
    tb_dat = 16'($urandom);
    for (int k = 1; k <= 6; k++) begin
      step(1);
      if (k == 1) tb_drv = 1'b0;
      if (wr_evt) pulses++;
      if (k == 3) begin
        chk("wr_evt", wr_evt, 1'b1);
        chk("wr_evt_addr", wr_evt_addr, a);
        chk("wr_evt_data", wr_evt_data, d);
        loc_wr_en = 1'b0;
      end
      if (coll && k == 2) begin
        loc_addr    = a[REG_AW-1:0];
        loc_wr_data = 16'h1111;
        loc_wr_en   = 1'b1;
      end
    end
    chk("wr_pulses", pulses, 1);
    if (coll) model_rf[a[REG_AW-1:0]] = 16'h1111;
    if (a[9:REG_AW] == 0) model_rf[a[REG_AW-1:0]] = d;
  endtask

  initial begin
    int hi_cnt;
    int op;
    logic [9:0]  ra;
    logic [15:0] rd;

    model_clear();
    exp_err = 3'b000;
    step(3);
    rst_n = 1'b1;
    step(2);

    // Reset values.
    chk("rst_ready", ready, 1'b1);
    chk("rst_err", err_flags, 3'b000);
    chk("rst_wr_evt", wr_evt, 1'b0);
    chk("rst_wr_evt_addr", wr_evt_addr, 10'h000);
    chk("rst_wr_evt_data", wr_evt_data, 16'h0000);
    chk("rst_loc_rd", loc_rd_data, 16'h0000);
    chk_bus_z("rst_bus_z");
    loc_check("rst_rf0", 6'd0);

    // Local write then bus read.
    loc_write(6'd5, 16'hA5A5);
    bus_read("rd5", 10'd5, 5);

    // Bus write then local readback.
    bus_write(10'd3, 16'h1234, 5, 1'b0);
    loc_check("loc3", 6'd3);

    // Out-of-range address.
    loc_write(6'd63, 16'h6363);
    bus_read("rd3ff", 10'h3FF, 5);
    bus_write(10'h3FF, 16'hDEAD, 5, 1'b0);
    loc_check("rf63_kept", 6'd63);

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 3);
      if ($urandom_range(0, 7) == 0) ra = 10'($urandom_range(64, 1023));
      else                           ra = 10'($urandom_range(0, 63));
      rd = 16'($urandom);
      case (op)
        0: loc_write(ra[REG_AW-1:0], rd);
        1: bus_write(ra, rd, $urandom_range(2, 6), 1'b0);
        2: bus_read("rnd_rd", ra, $urandom_range(4, 6));
        default: loc_check("rnd_loc", ra[REG_AW-1:0]);
      endcase
    end

    // Local write and bus commit to the same index in the same cycle.
    bus_write(10'd7, 16'h2222, 5, 1'b1);
    loc_addr = 6'd7;
    step(1);
    chk("collision", loc_rd_data, 16'h2222);

    // Valid chip reset: clear, boot window, read during boot.
    loc_write(6'd5, 16'hCAFE);
    loc_addr = 6'd5;
    w_rst_n  = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      step(1);
      if (c == 1) chk("rst_det_c1", ready, 1'b1);
      if (c == 2) chk("rst_det_c2", ready, 1'b0);
      if (c == 3) chk("pre_clear", loc_rd_data, 16'hCAFE);
    end
    w_rst_n = 1'b1;
    hi_cnt  = 0;
    addr    = 10'd5;
    for (int c = 1; c <= BOOT + 3; c++) begin
      step(1);
      if (c < BOOT + 3 && ready) hi_cnt++;
      if (c == 5) chk("boot_cleared", loc_rd_data, 16'h0000);
      if (c == 10) begin cs_n = 1'b0; rd_n = 1'b0; end
      if (c == 13) chk("boot_rd", data, 16'h0000);
      if (c == 16) begin cs_n = 1'b1; rd_n = 1'b1; end
      if (c == 30) chk("boot_err", err_flags, CHK_EN ? 3'b010 : 3'b000);
      if (c == BOOT + 2) chk("boot_ready_lo", ready, 1'b0);
      if (c == BOOT + 3) chk("boot_ready_hi", ready, 1'b1);
    end
    chk("boot_ready_stayed_lo", hi_cnt, 0);
    model_clear();
    loc_check("clr63", 6'd63);
    loc_check("clr7", 6'd7);
    bus_read("rd_after_boot", 10'd3, 5);

    // Glitch on w_rst_n: no clear, back to Idle.
    do_rst();
    loc_write(6'd9, 16'hBEEF);
    w_rst_n = 1'b0;
    step(20);
    chk("glitch_ready_lo", ready, 1'b0);
    w_rst_n = 1'b1;
    step(6);
    chk("glitch_ready_hi", ready, 1'b1);
    chk("glitch_err", err_flags, CHK_EN ? 3'b100 : 3'b000);
    loc_check("glitch_kept", 6'd9);
    bus_read("glitch_rd", 10'd9, 4);

    // rst_n asserted mid-read releases the bus at once.
    addr = 10'd9;
    cs_n = 1'b0;
    rd_n = 1'b0;
    step(4);
    chk("abort_rd_drv", data, 16'hBEEF);
    rst_n = 1'b0;
    #1;
    chk_bus_z("abort_rd_z");
    cs_n = 1'b1;
    rd_n = 1'b1;
    step(2);
    rst_n = 1'b1;
    model_clear();
    step(2);

    // rst_n asserted mid-write: no commit.
    addr   = 10'd2;
    tb_dat = 16'h7777;
    tb_drv = 1'b1;
    cs_n   = 1'b0;
    wr_n   = 1'b0;
    step(3);
    rst_n = 1'b0;
    step(1);
    cs_n   = 1'b1;
    wr_n   = 1'b1;
    tb_drv = 1'b0;
    step(1);
    rst_n  = 1'b1;
    hi_cnt = 0;
    for (int c = 1; c <= 6; c++) begin
      step(1);
      if (wr_evt) hi_cnt++;
    end
    chk("abort_wr_no_evt", hi_cnt, 0);
    loc_check("abort_wr_rf2", 6'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
